// File: rtl/store_narrower_if.sv
// Store request side and narrow memory write port of the store narrower.
// The slave modport is the narrower's view; the master modport is the EX/MEM and memory side.
interface store_narrower_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_size;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [1:0]        mem_be;
    logic              mem_last;
    logic              err_misalign;
    logic              busy;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last,
               err_misalign, busy
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, mem_last,
               err_misalign, busy
    );
endinterface

// File: rtl/store_narrower.sv
// Splits a 32-bit SB/SH/SW store into one or two 16-bit beats with byte enables.
// A word goes out low half first (little-endian), the upper half is latched at accept.
module store_narrower #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    store_narrower_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t            state_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [MEM_W-1:0]  wdata_q;
    logic [MEM_W-1:0]  upper_q;
    logic [1:0]        be_q;
    logic              last_q;
    logic              err_q;
    logic              illegal;

    assign illegal = (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

    // Second-beat address wraps naturally at the top of the address space.
    assign addr_d = addr_q + ADDR_W'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            upper_q <= '0;
            be_q    <= 2'b00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= BEAT0;
                            valid_q <= 1'b1;
                            upper_q <= bus.req_data[DATA_W-1:MEM_W];
                            if (bus.req_size == 2'b00) begin
                                addr_q  <= {bus.req_addr[ADDR_W-1:1], 1'b0};
                                wdata_q <= {2{bus.req_data[7:0]}};
                                be_q    <= bus.req_addr[0] ? 2'b10 : 2'b01;
                                last_q  <= 1'b1;
                            end else begin
                                addr_q  <= bus.req_addr;
                                wdata_q <= bus.req_data[MEM_W-1:0];
                                be_q    <= 2'b11;
                                last_q  <= (bus.req_size == 2'b01);
                            end
                        end
                    end
                end
                BEAT0: begin
                    if (bus.mem_ready) begin
                        if (!last_q) begin
                            state_q <= BEAT1;
                            addr_q  <= addr_d;
                            wdata_q <= upper_q;
                            be_q    <= 2'b11;
                            last_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (bus.mem_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.mem_valid    = valid_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_be       = be_q;
    assign bus.mem_last     = last_q;
    assign bus.err_misalign = err_q;
endmodule

// File: tb/tb_store_narrower.sv
// Directed bench for store_narrower: inputs driven and outputs sampled on the falling edge.
module tb_store_narrower;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hs_cnt;

    store_narrower_if #(.ADDR_W(32), .DATA_W(32), .MEM_W(16)) bus ();

    store_narrower #(.ADDR_W(32), .DATA_W(32), .MEM_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_valid && bus.mem_ready) hs_cnt++;
    end

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = s;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = 2'b00;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.err_misalign !== 1'b0 || bus.mem_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b ready=%b busy=%b err=%b last=%b, want 0 1 0 0 0",
                     bus.mem_valid, bus.req_ready, bus.busy, bus.err_misalign, bus.mem_last);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 16'h0 || bus.mem_be !== 2'b00) begin
            errors++;
            $display("FAIL reset_payload: addr=%h wdata=%h be=%b, want 0 0 00",
                     bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sw;
        bus.mem_ready = 1'b1;
        drive_req(32'h100, 32'hDEADBEEF, 2'b10);
        checks++;
        if (bus.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL sw_pre_valid: got %b want 0", bus.mem_valid);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_data  = 32'h0;
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 16'hBEEF ||
            bus.mem_be !== 2'b11 || bus.mem_last !== 1'b0 || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL sw_beat0: v=%b a=%h d=%h be=%b l=%b rdy=%b busy=%b, want 1 100 beef 11 0 0 1",
                     bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_last, bus.req_ready, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h102 || bus.mem_wdata !== 16'hDEAD ||
            bus.mem_be !== 2'b11 || bus.mem_last !== 1'b1) begin
            errors++;
            $display("FAIL sw_beat1: v=%b a=%h d=%h be=%b l=%b, want 1 102 dead 11 1",
                     bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_last);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL sw_done: v=%b rdy=%b busy=%b, want 0 1 0", bus.mem_valid, bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_sb;
        logic [31:0] addrs [2] = '{32'h203, 32'h202};
        logic [1:0]  bes   [2] = '{2'b10, 2'b01};
        for (int i = 0; i < 2; i++) begin
            drive_req(addrs[i], 32'h000000A5, 2'b00);
            @(negedge clk);
            bus.req_valid = 1'b0;
            checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h202 || bus.mem_wdata !== 16'hA5A5 ||
                bus.mem_be !== bes[i] || bus.mem_last !== 1'b1) begin
                errors++;
                $display("FAIL sb_beat[%0d]: v=%b a=%h d=%h be=%b l=%b, want 1 202 a5a5 %b 1",
                         i, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_last, bes[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL sb_done[%0d]: v=%b rdy=%b, want 0 1", i, bus.mem_valid, bus.req_ready);
            end
        end
    endtask

    task automatic test_misalign;
        logic [31:0] addrs [3] = '{32'h301, 32'h302, 32'h300};
        logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            drive_req(addrs[i], 32'h12345678, sizes[i]);
            @(negedge clk);
            bus.req_valid = 1'b0;
            checks++;
            if (bus.err_misalign !== 1'b1 || bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL misalign_pulse[%0d]: err=%b v=%b rdy=%b, want 1 0 1",
                         i, bus.err_misalign, bus.mem_valid, bus.req_ready);
            end
            @(negedge clk);
            checks++;
            if (bus.err_misalign !== 1'b0 || bus.mem_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL misalign_clear[%0d]: err=%b v=%b busy=%b, want 0 0 0",
                         i, bus.err_misalign, bus.mem_valid, bus.busy);
            end
        end
    endtask

    task automatic test_stall;
        int hs0;
        hs0 = hs_cnt;
        bus.mem_ready = 1'b0;
        drive_req(32'h400, 32'h12345678, 2'b10);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_data  = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h400 || bus.mem_wdata !== 16'h5678 ||
                bus.mem_be !== 2'b11 || bus.mem_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_beat0[%0d]: v=%b a=%h d=%h be=%b l=%b, want 1 400 5678 11 0",
                         i, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_last);
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h402 || bus.mem_wdata !== 16'h1234 ||
                bus.mem_be !== 2'b11 || bus.mem_last !== 1'b1 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_beat1[%0d]: v=%b a=%h d=%h be=%b l=%b busy=%b, want 1 402 1234 11 1 1",
                         i, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_last, bus.busy);
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0 || (hs_cnt - hs0) !== 2) begin
            errors++;
            $display("FAIL stall_done: v=%b busy=%b handshakes=%0d, want 0 0 2",
                     bus.mem_valid, bus.busy, hs_cnt - hs0);
        end
    endtask

    task automatic test_back_to_back;
        bus.mem_ready = 1'b1;
        drive_req(32'hFFFFFFFC, 32'hCAFEF00D, 2'b10);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_addr !== 32'hFFFFFFFC || bus.mem_wdata !== 16'hF00D || bus.mem_last !== 1'b0) begin
            errors++;
            $display("FAIL wrap_beat0: a=%h d=%h l=%b, want fffffffc f00d 0", bus.mem_addr, bus.mem_wdata, bus.mem_last);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_addr !== 32'hFFFFFFFE || bus.mem_wdata !== 16'hCAFE || bus.mem_last !== 1'b1) begin
            errors++;
            $display("FAIL wrap_beat1: a=%h d=%h l=%b, want fffffffe cafe 1", bus.mem_addr, bus.mem_wdata, bus.mem_last);
        end
        @(negedge clk);
        // Two halfword stores with req_valid held high throughout.
        drive_req(32'h10, 32'h00001111, 2'b01);
        @(negedge clk);
        drive_req(32'h20, 32'h00002222, 2'b01);
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_wdata !== 16'h1111 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: v=%b a=%h d=%h rdy=%b, want 1 10 1111 0",
                     bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bubble: v=%b rdy=%b, want 0 1", bus.mem_valid, bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 16'h2222 || bus.mem_be !== 2'b11) begin
            errors++;
            $display("FAIL b2b_second: v=%b a=%h d=%h be=%b, want 1 20 2222 11",
                     bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int hs0;
        bus.mem_ready = 1'b1;
        drive_req(32'h500, 32'hAAAA5555, 2'b10);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h502 || bus.mem_last !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_beat1: v=%b a=%h l=%b, want 1 502 1", bus.mem_valid, bus.mem_addr, bus.mem_last);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: v=%b busy=%b rdy=%b l=%b, want 0 0 1 0",
                     bus.mem_valid, bus.busy, bus.req_ready, bus.mem_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        hs0 = hs_cnt;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1 || (hs_cnt - hs0) !== 0) begin
            errors++;
            $display("FAIL rst_mid_after: v=%b rdy=%b stray=%0d, want 0 1 0",
                     bus.mem_valid, bus.req_ready, hs_cnt - hs0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs_cnt = 0;
        test_reset();
        test_sw();
        test_sb();
        test_misalign();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
